pri_rr_arb: RTL and testbench
=============================

// Module: pri_rr_arb
// PURPOSE
//  N-way round-robin arbiter with bus lock for the peripheral-side NoC return path.
//  - Slave response FIFOs raise level requests.
//  - Arbiter issues a registered one-hot grant.
//  - Grant is held while the output sequencer asserts lock during a packet.
//  - Lock release frees the bus for the next requester.
// PARAMETERS
//  N             4   number of requesters (>=2)
//  OFFER_CYCLES  2   cycles an unlocked grant is held before withdrawal (>=1)
// PORTS
//  clk    in   1   single clock, rising edge
//  reset  in   1   asynchronous, active-low reset
//  lock   in   1   owner holds bus; grant frozen while high
//  req    in   N   level requests; bit i = requester i
//  gnt    out  N   registered one-hot grant, or all-zero
//  gnt_id out  $clog2(N)  index of granted requester; 0 when gnt==0
//  busy   out  1   high when state != IDLE
// BEHAVIOUR
//  - Interface: one clock; reset is asynchronous and active-low.
//  - Reset (reset==0, async): gnt=0, gnt_id=0, busy=0, state=IDLE.
//    - Reset also sets ptr=N-1, so index 0 has first priority.
//  - State IDLE:
//    - If req!=0 at an edge: gnt<=one-hot(pick), ptr<=pick, cnt<=1, go to GRANTED.
//    - Latency is 1 cycle from req to gnt.
//    - Else gnt stays 0.
//  - Pick rule: first set req bit scanning ptr+1, ptr+2, ... modulo N.
//    - Wrap-around from index N-1 to 0 is mandatory.
//  - State GRANTED (gnt held):
//    - lock==1 -> go to LOCKED.
//    - Else if cnt==OFFER_CYCLES -> gnt<=0, go to IDLE. The owner forfeits its turn; ptr is kept.
//    - Else cnt<=cnt+1.
//  - State LOCKED: gnt held unchanged while lock==1.
//    - Any req changes are ignored, including the owner dropping its req.
//    - lock==0 -> gnt<=0, go to IDLE.
//    - This guarantees at least one all-zero gnt cycle between consecutive grants.
//  - Simultaneous events:
//    - New requests arriving during GRANTED/LOCKED wait; they are considered on the IDLE cycle.
//    - lock high in IDLE with gnt==0 has no effect.
//  - A requester deasserting req before being granted loses nothing; no request is stored.
//  - gnt is always one-hot or zero. A non-one-hot gnt is a design error; assert it in simulation.
//  - Reset mid-packet drops gnt immediately, asynchronously, regardless of lock.
//  - All outputs are driven from flops; there is no combinational req->gnt path.
// CONFIGURATION
//  - Macro ARB_FIXED_PRI_EN defined:
//    - Pick = lowest-index set req bit every time.
//    - ptr is not used.
//    - All other states and timing are unchanged.
//  - Macro undefined (default): round-robin pick as above.
// STRUCTURE
//  - Package arb_pkg:
//    - typedef enum logic [1:0] {IDLE, GRANTED, LOCKED} arb_state_e.
//    - localparam ARB_N_DEF=4.
//    - function onehot(idx).
//  - Sub-module rr_pick (combinational):
//    - Inputs: req[N], ptr.
//    - Outputs: valid, idx.
//    - Implemented as a rotate, priority-encode, un-rotate.
//    - Under ARB_FIXED_PRI_EN it reduces to a plain priority encoder.
//  - Top module holds the state register, ptr, cnt, gnt/gnt_id flops and the SVA one-hot check.
// TESTING
//  1. Reset with req=4'b1111, lock=0; release reset.
//     - Next edge: gnt=4'b0001.
//     - Without lock, after OFFER_CYCLES: gnt=0.
//     - Following grants rotate 0010, 0100, 1000, 0001.
//  2. Lock hold:
//     - Apply req=4'b0100; gnt=0100 next edge.
//     - Assert lock, drop req, raise req[0]: gnt stays 0100 for the full 20-cycle lock.
//     - After lock falls: gnt=0 for one cycle, then 0001.
//  3. Wrap-around: last grant idx 3, then req=4'b1001 -> gnt=4'b0001. Last grant idx 0 -> 4'b1000.
//  4. Async reset mid-LOCKED:
//     - Drive reset=0 between edges: gnt=0 and busy=0 immediately.
//     - After release with req=4'b1000: gnt=4'b1000.
//  5. Offer timeout: req pulsed 1 cycle on idx 2, lock never set.
//     - gnt=0100 for exactly OFFER_CYCLES cycles, then 0 and IDLE.
//  6. ARB_FIXED_PRI_EN build with req=4'b1010 held, lock pulsed per grant:
//     - Every grant is 0010.
//     - idx 3 is granted only after req[1] drops.

Source files
------------

// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin NoC return-path arbiter.
// Provides arbiter state encoding, default width and one-hot helper.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANTED = 2'd1,
    LOCKED  = 2'd2
  } arb_state_e;

  localparam int ARB_N_DEF = 4;
  localparam int ARB_N_MAX = 32;

  function automatic logic [ARB_N_MAX-1:0] onehot(
    input int unsigned idx
  );
    logic [ARB_N_MAX-1:0] one;
    one = 1;
    return one << idx;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational requester picker: rotate, priority-encode, un-rotate.
// Ports: req (N level requests), ptr (last owner) -> valid, idx.
// ARB_FIXED_PRI_EN: plain lowest-index priority encoder, ptr ignored.
module rr_pick
  import arb_pkg::*;
#(
  parameter  int N = ARB_N_DEF,
  localparam int W = $clog2(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         valid,
  output logic [W-1:0] idx
);

  assign valid = |req;

`ifdef ARB_FIXED_PRI_EN
  logic unused_ptr;
  assign unused_ptr = ^ptr;

  always_comb begin
    idx = '0;
    for (int i = N-1; i >= 0; i--)
      if (req[i]) idx = W'(i);
  end
`else
  logic [2*N-1:0] dbl;
  logic [2*N-1:0] shf;
  logic [N-1:0]   rot;
  int             sh;
  int             k;
  int             s;

  // Bit 0 of rot is requester ptr+1, so the lowest set
  // bit is the next one after the last owner.
  always_comb begin
    dbl = {req, req};
    sh  = int'(ptr) + 1;
    shf = dbl >> sh;
    rot = shf[N-1:0];
    k   = 0;
    for (int i = N-1; i >= 0; i--)
      if (rot[i]) k = i;
    s = sh + k;
    if (s >= N) s = s - N;
    idx = W'(s);
  end
`endif

endmodule

// File: rtl/pri_rr_arb.sv
// N-way round-robin arbiter with bus lock, registered one-hot grant.
// Ports: clk, reset (async low), lock, req[N] -> gnt[N], gnt_id, busy.
// Optional macro ARB_FIXED_PRI_EN selects fixed lowest-index priority.
module pri_rr_arb
  import arb_pkg::*;
#(
  parameter  int N            = ARB_N_DEF,
  parameter  int OFFER_CYCLES = 2,
  localparam int W            = $clog2(N),
  localparam int CW           = $clog2(OFFER_CYCLES + 1)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         lock,
  input  logic [N-1:0] req,
  output logic [N-1:0] gnt,
  output logic [W-1:0] gnt_id,
  output logic         busy
);

  arb_state_e    state_q, state_d;
  logic [W-1:0]  ptr_q, ptr_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  gnt_q, gnt_d;
  logic [W-1:0]  id_q, id_d;
  logic          busy_q, busy_d;

  logic          pick_v;
  logic [W-1:0]  pick_idx;

  rr_pick #(.N(N)) u_pick (
    .req   (req),
    .ptr   (ptr_q),
    .valid (pick_v),
    .idx   (pick_idx)
  );

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    gnt_d   = gnt_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (pick_v) begin
          gnt_d   = N'(onehot(32'(pick_idx)));
          id_d    = pick_idx;
          ptr_d   = pick_idx;
          cnt_d   = CW'(1);
          state_d = GRANTED;
        end
      end
      GRANTED: begin
        if (lock) begin
          state_d = LOCKED;
        end else if (cnt_q == CW'(OFFER_CYCLES)) begin
          // Unused offer: owner forfeits, ptr kept.
          gnt_d   = '0;
          id_d    = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      LOCKED: begin
        if (!lock) begin
          gnt_d   = '0;
          id_d    = '0;
          state_d = IDLE;
        end
      end
      default: begin
        gnt_d   = '0;
        id_d    = '0;
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      ptr_q   <= W'(N-1);
      cnt_q   <= '0;
      gnt_q   <= '0;
      id_q    <= '0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      id_q    <= id_d;
      busy_q  <= busy_d;
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = id_q;
  assign busy   = busy_q;

  a_gnt_onehot: assert property (
    @(posedge clk) disable iff (!reset) $onehot0(gnt_q)
  );

endmodule

// File: tb/tb_pri_rr_arb.sv
// Scoreboard bench for pri_rr_arb: directed vectors push expected
// grants, a monitor pops and compares on each falling edge.
module tb_pri_rr_arb;

  logic       clk = 1'b0;
  logic       reset;
  logic       lock;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       busy;

  int n_chk  = 0;
  int n_fail = 0;

  logic [3:0] eg_q[$];
  logic       eb_q[$];
  string      nm_q[$];
  event       chk_ev;

  pri_rr_arb #(.N(4), .OFFER_CYCLES(2)) dut (
    .clk    (clk),
    .reset  (reset),
    .lock   (lock),
    .req    (req),
    .gnt    (gnt),
    .gnt_id (gnt_id),
    .busy   (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [1:0] idx_of(input logic [3:0] g);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++)
      if (g[i]) r = 2'(i);
    return r;
  endfunction

  // Monitor: compares whatever is queued at each falling edge
  // or on an explicit mid-cycle check request.
  initial begin
    logic [3:0] eg;
    logic       eb;
    string      nm;
    forever begin
      @(negedge clk or chk_ev);
      while (eg_q.size() > 0) begin
        eg = eg_q.pop_front();
        eb = eb_q.pop_front();
        nm = nm_q.pop_front();
        n_chk++;
        if ({gnt, gnt_id, busy} !== {eg, idx_of(eg), eb}) begin
          n_fail++;
          $display("FAIL %s: gnt=%b id=%0d busy=%b, want gnt=%b id=%0d busy=%b",
                   nm, gnt, gnt_id, busy, eg, idx_of(eg), eb);
        end
      end
    end
  end

  task automatic push(input logic [3:0] eg, input logic eb,
                      input string nm);
    eg_q.push_back(eg);
    eb_q.push_back(eb);
    nm_q.push_back(nm);
  endtask

  // Drive inputs for the next edge; expect outputs after it.
  task automatic step(input logic [3:0] r, input logic l,
                      input logic [3:0] eg, input logic eb,
                      input string nm);
    req  = r;
    lock = l;
    @(posedge clk);
    push(eg, eb, nm);
    @(negedge clk);
  endtask

  task automatic now_chk(input logic [3:0] eg, input logic eb,
                         input string nm);
    push(eg, eb, nm);
    ->chk_ev;
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    lock  = 1'b0;
    req   = 4'b1111;
    @(negedge clk);
    @(negedge clk);
    now_chk(4'b0000, 1'b0, "reset_state");
    reset = 1'b1;

`ifdef ARB_FIXED_PRI_EN
    for (int n = 0; n < 3; n++) begin
      step(4'b1010, 1'b0, 4'b0010, 1'b1, "fix_grant");
      step(4'b1010, 1'b1, 4'b0010, 1'b1, "fix_lock");
      step(4'b1010, 1'b0, 4'b0000, 1'b0, "fix_rel");
    end
    step(4'b1010, 1'b0, 4'b0010, 1'b1, "fix_grant4");
    step(4'b1010, 1'b1, 4'b0010, 1'b1, "fix_lock4");
    step(4'b1000, 1'b0, 4'b0000, 1'b0, "fix_drop1");
    step(4'b1000, 1'b0, 4'b1000, 1'b1, "fix_idx3");
    step(4'b1000, 1'b0, 4'b1000, 1'b1, "fix_idx3_hold");
    step(4'b1000, 1'b0, 4'b0000, 1'b0, "fix_idx3_off");
`else
    // Rotation with no lock: each offer times out after 2 cycles.
    step(4'b1111, 1'b0, 4'b0001, 1'b1, "rot0_a");
    step(4'b1111, 1'b0, 4'b0001, 1'b1, "rot0_b");
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "rot0_off");
    step(4'b1111, 1'b0, 4'b0010, 1'b1, "rot1_a");
    step(4'b1111, 1'b0, 4'b0010, 1'b1, "rot1_b");
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "rot1_off");
    step(4'b1111, 1'b0, 4'b0100, 1'b1, "rot2_a");
    step(4'b1111, 1'b0, 4'b0100, 1'b1, "rot2_b");
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "rot2_off");
    step(4'b1111, 1'b0, 4'b1000, 1'b1, "rot3_a");
    step(4'b1111, 1'b0, 4'b1000, 1'b1, "rot3_b");
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "rot3_off");
    step(4'b1111, 1'b0, 4'b0001, 1'b1, "rot4_a");
    step(4'b1111, 1'b0, 4'b0001, 1'b1, "rot4_b");
    step(4'b1111, 1'b0, 4'b0000, 1'b0, "rot4_off");

    // Lock hold for 20 cycles, req changes ignored.
    step(4'b0100, 1'b0, 4'b0100, 1'b1, "lk_grant");
    for (int i = 0; i < 20; i++)
      step(4'b0001, 1'b1, 4'b0100, 1'b1, "lk_hold");
    step(4'b0001, 1'b0, 4'b0000, 1'b0, "lk_gap");
    step(4'b0001, 1'b0, 4'b0001, 1'b1, "lk_next");
    step(4'b0000, 1'b0, 4'b0001, 1'b1, "lk_next_b");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "lk_next_off");

    // Wrap-around both ways.
    step(4'b1000, 1'b0, 4'b1000, 1'b1, "wr_g3");
    step(4'b1000, 1'b0, 4'b1000, 1'b1, "wr_g3_b");
    step(4'b1001, 1'b0, 4'b0000, 1'b0, "wr_g3_off");
    step(4'b1001, 1'b0, 4'b0001, 1'b1, "wr_3to0");
    step(4'b1001, 1'b0, 4'b0001, 1'b1, "wr_3to0_b");
    step(4'b1001, 1'b0, 4'b0000, 1'b0, "wr_3to0_off");
    step(4'b1001, 1'b0, 4'b1000, 1'b1, "wr_0to3");
    step(4'b0000, 1'b0, 4'b1000, 1'b1, "wr_0to3_b");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "wr_0to3_off");

    // Offer timeout on a one-cycle request pulse.
    step(4'b0100, 1'b0, 4'b0100, 1'b1, "to_a");
    step(4'b0000, 1'b0, 4'b0100, 1'b1, "to_b");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_off");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "to_idle");

    // Async reset while LOCKED.
    step(4'b1000, 1'b0, 4'b1000, 1'b1, "ar_grant");
    step(4'b1000, 1'b1, 4'b1000, 1'b1, "ar_lock");
    step(4'b1000, 1'b1, 4'b1000, 1'b1, "ar_lock_b");
    #2;
    reset = 1'b0;
    #1;
    now_chk(4'b0000, 1'b0, "ar_async");
    @(negedge clk);
    now_chk(4'b0000, 1'b0, "ar_held");
    reset = 1'b1;
    step(4'b1000, 1'b0, 4'b1000, 1'b1, "ar_after");
    step(4'b0000, 1'b1, 4'b1000, 1'b1, "ar_after_lk");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "ar_after_rel");

    // Lock in IDLE has no effect.
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_lock_a");
    step(4'b0000, 1'b1, 4'b0000, 1'b0, "idle_lock_b");
    step(4'b0010, 1'b1, 4'b0010, 1'b1, "idle_lock_req");
    step(4'b0000, 1'b1, 4'b0010, 1'b1, "idle_lock_hold");
    step(4'b0000, 1'b0, 4'b0000, 1'b0, "idle_lock_rel");
`endif

    @(negedge clk);
    n_chk++;
    if (eg_q.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d left, want 0", eg_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
